// File: rtl/pc_unit_if.sv
// Control/status bundle between the fetch sequencer and the PC unit.
interface pc_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             EN;
    logic             BR_TAKEN;
    logic [WIDTH-1:0] BR_TGT;
    logic             CALL;
    logic             RET;
    logic [WIDTH-1:0] PC;
    logic [WIDTH-1:0] PC_PLUS;
    logic             RAS_EMPTY;
    logic             RAS_FULL;
    logic             RAS_ERR;

    modport master (
        output EN, BR_TAKEN, BR_TGT, CALL, RET,
        input  PC, PC_PLUS, RAS_EMPTY, RAS_FULL, RAS_ERR
    );

    modport slave (
        input  EN, BR_TAKEN, BR_TGT, CALL, RET,
        output PC, PC_PLUS, RAS_EMPTY, RAS_FULL, RAS_ERR
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter with branch/call/return redirection and a circular return-address stack.
module pc_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int unsigned      STEP      = 4,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input logic      CLK,
    input logic      RST,
    pc_unit_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    typedef enum logic [2:0] {
        OP_SEQ,
        OP_BRANCH,
        OP_CALL,
        OP_RET,
        OP_ILLEGAL
    } op_e;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic [WIDTH-1:0] ras [RAS_DEPTH];
    logic [PTR_W-1:0] sp;
    logic [PTR_W-1:0] sp_prev;
    logic [CNT_W-1:0] count;
    logic             err;
    logic             empty;
    logic             full;
    op_e              op;

    assign pc_plus = pc + WIDTH'(STEP);
    assign sp_prev = sp - PTR_W'(1);
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(RAS_DEPTH));

    always_comb begin
        op = OP_SEQ;
        if (bus.CALL && bus.RET) op = OP_ILLEGAL;
        else if (bus.RET)        op = OP_RET;
        else if (bus.CALL)       op = OP_CALL;
        else if (bus.BR_TAKEN)   op = OP_BRANCH;
    end

    // sp always points at the next write slot; once full it also points at the
    // oldest entry, so a push on a full stack overwrites it in place.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc    <= RESET_VEC;
            sp    <= '0;
            count <= '0;
            err   <= 1'b0;
        end else if (bus.EN) begin
            unique case (op)
                OP_ILLEGAL: begin
                    pc  <= pc_plus;
                    err <= 1'b1;
                end
                OP_RET: begin
                    if (empty) begin
                        pc  <= pc_plus;
                        err <= 1'b1;
                    end else begin
                        pc    <= ras[sp_prev];
                        sp    <= sp_prev;
                        count <= count - CNT_W'(1);
                    end
                end
                OP_CALL: begin
                    pc <= bus.BR_TGT;
                    sp <= sp + PTR_W'(1);
                    if (full) err   <= 1'b1;
                    else      count <= count + CNT_W'(1);
                end
                OP_BRANCH: pc <= bus.BR_TGT;
                default:   pc <= pc_plus;
            endcase
        end
    end

    // Entry storage carries no reset; stale contents are unreachable once count is 0.
    always_ff @(posedge CLK) begin
        if (bus.EN && op == OP_CALL) ras[sp] <= pc_plus;
    end

    assign bus.PC        = pc;
    assign bus.PC_PLUS   = pc_plus;
    assign bus.RAS_EMPTY = empty;
    assign bus.RAS_FULL  = full;
    assign bus.RAS_ERR   = err;
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning PC width in bits (legal range 8..64).
REQ-002 SHALL have parameter RESET_VEC, default 0, meaning the PC value loaded on reset.
REQ-003 SHALL have parameter STEP, default 4, meaning the sequential increment.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries (power of two, 2..16).
REQ-005 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port EN, input, 1 bit: advance enable; 0 = stall.
REQ-008 SHALL have port BR_TAKEN, input, 1 bit: redirect the PC to BR_TGT.
REQ-009 SHALL have port BR_TGT, input, WIDTH bits: branch/jump/call target.
REQ-010 SHALL have port CALL, input, 1 bit: jump to BR_TGT and push PC+STEP.
REQ-011 SHALL have port RET, input, 1 bit: pop the RAS top into the PC.
REQ-012 SHALL have port PC, output, WIDTH bits: current PC, driven directly from a register.
REQ-013 SHALL have port PC_PLUS, output, WIDTH bits: combinational PC+STEP.
REQ-014 SHALL have port RAS_EMPTY, output, 1 bit: stack count is 0.
REQ-015 SHALL have port RAS_FULL, output, 1 bit: stack count equals RAS_DEPTH.
REQ-016 SHALL have port RAS_ERR, output, 1 bit: sticky error flag, cleared only by reset.

Function
REQ-017 SHALL hold PC, RAS contents, count and RAS_ERR unchanged on any edge with EN=0, ignoring all control inputs.
REQ-018 SHALL, with EN=1, select next PC by priority: illegal (CALL&RET) > RET > CALL > BR_TAKEN > sequential.
REQ-019 SHALL compute the sequential value as PC+STEP modulo 2^WIDTH; the all-ones wrap to low addresses is legal and raises no error.
REQ-020 SHALL, on BR_TAKEN alone, load BR_TGT and leave the RAS untouched.
REQ-021 SHALL, on CALL, load BR_TGT and push PC_PLUS regardless of BR_TAKEN; count increments by 1.
REQ-022 SHALL, on CALL when full, overwrite the oldest entry (circular stack), keep count at RAS_DEPTH, and set RAS_ERR.
REQ-023 SHALL, on RET when not empty, load the top entry into the PC and decrement count by 1.
REQ-024 SHALL, on RET when empty, advance the PC sequentially, leave count at 0, and set RAS_ERR.
REQ-025 SHALL, on CALL and RET asserted together, advance the PC sequentially, leave the RAS unchanged, and set RAS_ERR.
REQ-026 SHALL make every redirect take effect on the PC in the cycle after the edge: one-cycle latency, no bubbles.
REQ-027 SHALL derive RAS_EMPTY and RAS_FULL from the registered count only, with no combinational path from inputs.

Reset
REQ-028 SHALL, while RST=1 and without waiting for a clock edge, force PC=RESET_VEC, count=0, RAS_EMPTY=1, RAS_FULL=0 and RAS_ERR=0.
REQ-029 SHALL, on reset asserted mid-operation, discard all stack contents; RAS entry storage values are don't-care after reset.
REQ-030 SHALL resume sequential fetch from RESET_VEC at the first rising CLK edge after RST deasserts with EN=1.

Verification
REQ-031 SHALL be verified with this scenario: reset with RESET_VEC=0x100, then 3 cycles with EN=1 -> PC reads 0x100, 0x104, 0x108, 0x10C; PC_PLUS = PC+4.
REQ-032 SHALL be verified with this scenario: PC=0x200, then CALL with BR_TGT=0x800, then 2 sequential cycles, then RET -> PC reads 0x800, 0x804, 0x808, 0x204; RAS_EMPTY=1 at the end.
REQ-033 SHALL be verified with this scenario: RAS_DEPTH=4 with 5 nested CALLs (pushes A..E), then 5 RETs -> RAS_FULL after the 4th push and RAS_ERR=1 after the 5th; RETs return E, D, C, B; the 5th RET advances the PC sequentially.
REQ-034 SHALL be verified with this scenario: EN=0 for 3 cycles while BR_TAKEN, CALL and RET toggle -> PC, count and RAS_ERR remain constant.
REQ-035 SHALL be verified with this scenario: WIDTH=8, PC=0xFC, sequential step -> PC=0x00 with RAS_ERR=0; then CALL and RET asserted together -> PC=0x04 and RAS_ERR=1.
REQ-036 SHALL be verified with this scenario: RST pulsed asynchronously mid-cycle with 2 entries stacked -> PC=RESET_VEC and RAS_EMPTY=1 immediately, before the next CLK edge.
